// File: rtl/ring_router_pkg.sv
// Shared definitions for the ring router node: route codes, the
// destination-field extraction helper and a saturating counter helper.
package ring_router_pkg;

   // Output port index doubles as the route code; DROP has no FIFO.
   typedef enum logic [1:0] {
      PORT_LEFT  = 2'd0,
      PORT_RIGHT = 2'd1,
      PORT_LOCAL = 2'd2,
      PORT_DROP  = 2'd3
   } routeT;

   localparam int NUM_PORTS = 3;

   // Destination address sits in the top addrW bits of the packet.
   // The packet is passed zero-extended to 64 bits, so dataW must not exceed 64.
   function automatic int destField(input logic [63:0] data, input int dataW, input int addrW);
      logic [63:0] shifted;
      shifted = data >> (dataW - addrW);
      return int'(shifted & ((64'd1 << addrW) - 64'd1));
   endfunction

   // 16-bit counter add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] satAdd(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + 17'(inc);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-output packet buffer: synchronous push/pop, show-ahead head.
// Push while full and pop while empty are ignored; an empty FIFO shows 0.
module router_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              push,
   input  logic [DATA_W-1:0] pushData,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] headData
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  count;
   logic              doPush;
   logic              doPop;

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign doPush   = push & ~full;
   assign doPop    = pop & ~empty;
   assign headData = empty ? '0 : mem[rdPtr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ring_router_node.sv
// Ring router node: left, right and local inputs routed by shortest path
// into per-output FIFOs with round-robin arbitration per output.
// Optional statistics counters are built when ROUTER_STATS_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on the same cycle's pop at that output.
module ring_router_node
   import ring_router_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 3,
   parameter int NUM_NODES  = 5,
   parameter int NODE_IP    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              shiftInCLK,
   input  logic              shiftInRSTn,
   input  logic [DATA_W-1:0] shiftInLeftData,
   input  logic              shiftInLeftValid,
   output logic              shiftInLeftReady,
   input  logic [DATA_W-1:0] shiftInRightData,
   input  logic              shiftInRightValid,
   output logic              shiftInRightReady,
   input  logic [DATA_W-1:0] shiftInData,
   input  logic              shiftInValid,
   output logic              shiftInReady,
   output logic [DATA_W-1:0] shiftOutLeftData,
   output logic              shiftOutLeftValid,
   input  logic              shiftOutLeftReady,
   output logic [DATA_W-1:0] shiftOutRightData,
   output logic              shiftOutRightValid,
   input  logic              shiftOutRightReady,
   output logic [DATA_W-1:0] shiftOutData,
   output logic              shiftOutValid,
   input  logic              shiftOutReady,
`ifdef ROUTER_STATS_EN
   output logic [15:0]       statFwdCount,
   output logic [15:0]       statDelivCount,
   output logic [15:0]       statDropCount,
`endif
   output logic              dropPulse
);

   logic [DATA_W-1:0] inData   [NUM_PORTS];
   logic [NUM_PORTS-1:0] inValid;
   logic [NUM_PORTS-1:0] inReady;
   logic [NUM_PORTS-1:0] isDrop;
   logic [1:0]        routeCode [NUM_PORTS];
   logic [NUM_PORTS-1:0] grant  [NUM_PORTS];
   logic [1:0]        grantIdx  [NUM_PORTS];
   logic [NUM_PORTS-1:0] hasGrant;
   logic [1:0]        rrPtr     [NUM_PORTS];
   logic [NUM_PORTS-1:0] fifoPush;
   logic [NUM_PORTS-1:0] fifoPop;
   logic [NUM_PORTS-1:0] fifoFull;
   logic [NUM_PORTS-1:0] fifoEmpty;
   logic [NUM_PORTS-1:0] outReady;
   logic [DATA_W-1:0] pushData  [NUM_PORTS];
   logic [DATA_W-1:0] headData  [NUM_PORTS];
   logic [NUM_PORTS-1:0] dropAcc;

   // Shortest-path decision; ties (d == NUM_NODES/2) go right.
   function automatic routeT routeOf(input logic [DATA_W-1:0] data);
      int dest;
      int d;
      dest = destField(64'(data), DATA_W, ADDR_W);
      d    = (dest - NODE_IP + NUM_NODES) % NUM_NODES;
      if (dest >= NUM_NODES)      return PORT_DROP;
      else if (d == 0)            return PORT_LOCAL;
      else if (d <= NUM_NODES/2)  return PORT_RIGHT;
      else                        return PORT_LEFT;
   endfunction

   // Round-robin search position k steps after ptr, modulo 3.
   function automatic logic [1:0] rrIdx(input logic [1:0] ptr, input int k);
      return 2'((int'(ptr) + k) % NUM_PORTS);
   endfunction

   assign inData[0] = shiftInLeftData;
   assign inData[1] = shiftInRightData;
   assign inData[2] = shiftInData;
   assign inValid   = {shiftInValid, shiftInRightValid, shiftInLeftValid};
   assign outReady  = {shiftOutReady, shiftOutRightReady, shiftOutLeftReady};

   // Route decode for every input.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         routeCode[i] = routeOf(inData[i]);
         isDrop[i]    = (routeCode[i] == PORT_DROP);
      end
   end

   // Per-output round-robin grant among valid inputs routed to it.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         grant[o]    = '0;
         grantIdx[o] = 2'd0;
         hasGrant[o] = 1'b0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!hasGrant[o] && inValid[rrIdx(rrPtr[o], k)] &&
                routeCode[rrIdx(rrPtr[o], k)] == 2'(o)) begin
               hasGrant[o]                  = 1'b1;
               grantIdx[o]                  = rrIdx(rrPtr[o], k);
               grant[o][rrIdx(rrPtr[o], k)] = 1'b1;
            end
         end
         fifoPush[o] = hasGrant[o] & ~fifoFull[o] & shiftInRSTn;
         pushData[o] = inData[grantIdx[o]];
      end
   end

   // Input ready: drops always accepted; otherwise granted and target not full.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         inReady[i] = isDrop[i];
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (routeCode[i] == 2'(o) && grant[o][i] && !fifoFull[o]) inReady[i] = 1'b1;
         end
         inReady[i] = inReady[i] & shiftInRSTn;
      end
   end

   assign dropAcc           = inValid & inReady & isDrop;
   assign shiftInLeftReady  = inReady[0];
   assign shiftInRightReady = inReady[1];
   assign shiftInReady      = inReady[2];

   // Round-robin pointers move past the winner only when a push happens.
   always_ff @(posedge shiftInCLK) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (!shiftInRSTn)     rrPtr[o] <= 2'd0;
         else if (fifoPush[o]) rrPtr[o] <= (grantIdx[o] == 2'd2) ? 2'd0 : grantIdx[o] + 2'd1;
      end
   end

   // One pulse per cycle with any drop, however many inputs dropped.
   always_ff @(posedge shiftInCLK) begin
      if (!shiftInRSTn) dropPulse <= 1'b0;
      else              dropPulse <= |dropAcc;
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : gOut
      assign fifoPop[o] = ~fifoEmpty[o] & outReady[o];
      router_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) uFifo (
         .clk      (shiftInCLK),
         .rstN     (shiftInRSTn),
         .push     (fifoPush[o]),
         .pushData (pushData[o]),
         .pop      (fifoPop[o]),
         .full     (fifoFull[o]),
         .empty    (fifoEmpty[o]),
         .headData (headData[o])
      );
   end

   assign shiftOutLeftData   = headData[0];
   assign shiftOutLeftValid  = ~fifoEmpty[0];
   assign shiftOutRightData  = headData[1];
   assign shiftOutRightValid = ~fifoEmpty[1];
   assign shiftOutData       = headData[2];
   assign shiftOutValid      = ~fifoEmpty[2];

`ifdef ROUTER_STATS_EN
   // Saturating traffic counters: ring forwards, local deliveries, drops.
   always_ff @(posedge shiftInCLK) begin
      if (!shiftInRSTn) begin
         statFwdCount   <= '0;
         statDelivCount <= '0;
         statDropCount  <= '0;
      end else begin
         statFwdCount   <= satAdd(statFwdCount, 2'(fifoPush[0]) + 2'(fifoPush[1]));
         statDelivCount <= satAdd(statDelivCount, 2'(fifoPush[2]));
         statDropCount  <= satAdd(statDropCount, 2'($countones(dropAcc)));
      end
   end
`endif

endmodule

// File: tb/tb_ring_router_node.sv
// Directed bench for ring_router_node (NUM_NODES=5, NODE_IP=0).
// Per-input source queues feed a valid/ready driver; expected packets per
// output are queued by the stimulus and popped by an independent monitor.
module tb_ring_router_node;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] lData = '0, rData = '0, cData = '0;
   logic        lValid = 1'b0, rValid = 1'b0, cValid = 1'b0;
   logic        lReady, rReady, cReady;
   logic [31:0] oLData, oRData, oCData;
   logic        oLValid, oRValid, oCValid;
   logic        outLReady = 1'b1, outRReady = 1'b1, outCReady = 1'b1;
   logic        dropPulse;
`ifdef ROUTER_STATS_EN
   logic [15:0] statFwd, statDeliv, statDrop;
`endif

   logic [31:0] srcL[$], srcR[$], srcC[$];
   logic [31:0] expL[$], expR[$], expC[$];
   logic [31:0] monExp;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ring_router_node #(
      .DATA_W(32), .ADDR_W(3), .NUM_NODES(5), .NODE_IP(0), .FIFO_DEPTH(4)
   ) dut (
      .shiftInCLK         (clk),
      .shiftInRSTn        (rstn),
      .shiftInLeftData    (lData),
      .shiftInLeftValid   (lValid),
      .shiftInLeftReady   (lReady),
      .shiftInRightData   (rData),
      .shiftInRightValid  (rValid),
      .shiftInRightReady  (rReady),
      .shiftInData        (cData),
      .shiftInValid       (cValid),
      .shiftInReady       (cReady),
      .shiftOutLeftData   (oLData),
      .shiftOutLeftValid  (oLValid),
      .shiftOutLeftReady  (outLReady),
      .shiftOutRightData  (oRData),
      .shiftOutRightValid (oRValid),
      .shiftOutRightReady (outRReady),
      .shiftOutData       (oCData),
      .shiftOutValid      (oCValid),
      .shiftOutReady      (outCReady),
`ifdef ROUTER_STATS_EN
      .statFwdCount       (statFwd),
      .statDelivCount     (statDeliv),
      .statDropCount      (statDrop),
`endif
      .dropPulse          (dropPulse)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Driver: sample handshake at negedge, retire accepted heads and present
   // the next head just after the rising edge.
   initial begin : driver
      logic accL, accR, accC;
      forever begin
         @(negedge clk);
         accL = lValid & lReady;
         accR = rValid & rReady;
         accC = cValid & cReady;
         @(posedge clk);
         #1;
         if (accL) void'(srcL.pop_front());
         if (accR) void'(srcR.pop_front());
         if (accC) void'(srcC.pop_front());
         lValid = (srcL.size() > 0);
         lData  = lValid ? srcL[0] : '0;
         rValid = (srcR.size() > 0);
         rData  = rValid ? srcR[0] : '0;
         cValid = (srcC.size() > 0);
         cData  = cValid ? srcC[0] : '0;
      end
   end

   // Monitor: every output transfer must match the head of its expected queue.
   always @(negedge clk) begin
      if (rstn) begin
         if (oLValid && outLReady) begin
            if (expL.size() == 0) chk("left_out_unexpected", oLData, 32'hxxxx_xxxx);
            else begin monExp = expL.pop_front(); chk("left_out", oLData, monExp); end
         end
         if (oRValid && outRReady) begin
            if (expR.size() == 0) chk("right_out_unexpected", oRData, 32'hxxxx_xxxx);
            else begin monExp = expR.pop_front(); chk("right_out", oRData, monExp); end
         end
         if (oCValid && outCReady) begin
            if (expC.size() == 0) chk("local_out_unexpected", oCData, 32'hxxxx_xxxx);
            else begin monExp = expC.pop_front(); chk("local_out", oCData, monExp); end
         end
      end
   end

   initial begin : main
      int pulses, anyOut, validCnt, firstRun;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {29'd0, oLValid, oRValid, oCValid}, 32'd0);
      chk("rst_data_l", oLData, 32'd0);
      chk("rst_data_r", oRData, 32'd0);
      chk("rst_data_c", oCData, 32'd0);
      chk("rst_ready", {29'd0, lReady, rReady, cReady}, 32'd0);
      chk("rst_drop", {31'd0, dropPulse}, 32'd0);
      @(posedge clk); #2;
      rstn = 1'b1;
      cyc(1);

      // Local dest 1 -> right, one cycle after acceptance
      srcC.push_back(32'h2000_0000); expR.push_back(32'h2000_0000);
      @(posedge clk); @(negedge clk);
      chk("t1_not_yet", {31'd0, oRValid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("t1_right_valid", {31'd0, oRValid}, 32'd1);
      chk("t1_right_data", oRData, 32'h2000_0000);
      chk("t1_others_idle", {30'd0, oLValid, oCValid}, 32'd0);
      cyc(3);

      // Dest 4 goes left; own address loops back; right-in dest 0 delivers; left-in dest 3 goes left
      srcC.push_back(32'h8000_0000); expL.push_back(32'h8000_0000); cyc(4);
      srcC.push_back(32'h0000_0000); expC.push_back(32'h0000_0000); cyc(4);
      srcR.push_back(32'h0000_0011); expC.push_back(32'h0000_0011); cyc(4);
      srcL.push_back(32'h6000_0022); expL.push_back(32'h6000_0022); cyc(4);

      // Contention for right output, ptr 0: left wins, then ptr=1 lets local win the next contest
      srcL.push_back(32'h4000_00AA); srcL.push_back(32'h4000_00AA);
      srcC.push_back(32'h4000_00BB);
      expR.push_back(32'h4000_00AA); expR.push_back(32'h4000_00BB); expR.push_back(32'h4000_00AA);
      cyc(8);

      // Backpressure: 4 fit, 5th stalls, then all drain in order back-to-back
      outRReady = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         srcC.push_back(32'h2000_0000 | 32'(i));
         expR.push_back(32'h2000_0000 | 32'(i));
      end
      cyc(10);
      @(negedge clk);
      chk("t4_stalled_left", 32'(srcC.size()), 32'd1);
      chk("t4_ready_low", {31'd0, cReady}, 32'd0);
      chk("t4_head", oRData, 32'h2000_0001);
      @(posedge clk); #2;
      outRReady = 1'b1;
      validCnt = 0; firstRun = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (oRValid) validCnt++;
         if (oRValid && i < 5) firstRun++;
      end
      chk("t4_drain_count", 32'(validCnt), 32'd5);
      chk("t4_drain_contig", 32'(firstRun), 32'd5);
      cyc(2);

      // Illegal destination: accepted, no output, single one-cycle pulse
      srcC.push_back(32'hA000_0000);
      pulses = 0; anyOut = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dropPulse) pulses++;
         if (oLValid | oRValid | oCValid) anyOut++;
      end
      chk("t5_pulses", 32'(pulses), 32'd1);
      chk("t5_no_output", 32'(anyOut), 32'd0);
      chk("t5_accepted", 32'(srcC.size()), 32'd0);
`ifdef ROUTER_STATS_EN
      chk("t5_stat_drop", {16'd0, statDrop}, 32'd1);
`endif
      @(posedge clk); #2;

      // Simultaneous drops on two inputs give one pulse
      srcL.push_back(32'hC000_0000); srcR.push_back(32'hE000_0000);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dropPulse) pulses++;
      end
      chk("t5_dual_pulse", 32'(pulses), 32'd1);
      @(posedge clk); #2;

      // Reset with 3 packets buffered in the right FIFO
      outRReady = 1'b0;
      for (int i = 1; i <= 3; i++) srcC.push_back(32'h2000_0100 | 32'(i));
      cyc(6);
      @(negedge clk);
      chk("t6_buffered", {31'd0, oRValid}, 32'd1);
      @(posedge clk); #2;
      srcL.push_back(32'hA000_0000);
      @(posedge clk); #2;
      rstn = 1'b0;
      @(negedge clk);
      chk("t6_ready_in_reset", {31'd0, lReady}, 32'd0);
      @(posedge clk); #2;
      rstn = 1'b1;
      outRReady = 1'b1;
      @(negedge clk);
      chk("t6_valid_cleared", {29'd0, oLValid, oRValid, oCValid}, 32'd0);
      chk("t6_data_cleared", oRData, 32'd0);
      anyOut = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (oRValid) anyOut++;
      end
      chk("t6_no_stale", 32'(anyOut), 32'd0);
      chk("t6_drop_after_reset", 32'(srcL.size()), 32'd0);
      @(posedge clk); #2;

      // Traffic resumes after reset: right-in dest 4 heads left
      srcR.push_back(32'h8000_0033); expL.push_back(32'h8000_0033);
      cyc(5);

      chk("end_expL_empty", 32'(expL.size()), 32'd0);
      chk("end_expR_empty", 32'(expR.size()), 32'd0);
      chk("end_expC_empty", 32'(expC.size()), 32'd0);
      chk("end_src_empty", 32'(srcL.size() + srcR.size() + srcC.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
